// File: rtl/hs_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo_pkg
// Description : Shared helpers for the req/ack elastic FIFO stage: pointer
//               width macro, clog2 helper and the req_l flag encoding.
// Revision    : 1.0 - initial release
// ============================================================================

// Pointer width for a given power-of-two depth.
`ifndef HS_PTR_W
`define HS_PTR_W(d) ($clog2(d))
`endif

package hs_fifo_pkg;

    // req_l flag encoding: IDLE = no request outstanding, WAIT_ACK = req_l high.
    localparam logic c_ST_IDLE     = 1'b0;
    localparam logic c_ST_WAIT_ACK = 1'b1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hs_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, one synchronous write port
//               and one registered read port. Storage has no reset; only the
//               read register is cleared so the stage output starts at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_fifo_mem
    import hs_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic [DATA_WIDTH-1:0] w_rdata_d;

    // Read register loads only on a read so the last value stays visible.
    always_comb begin
        w_rdata_d = r_rdata_q;
        if (i_re) begin
            w_rdata_d = r_mem_q[i_raddr];
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
    end

    // Registered read data, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_q <= '0;
        end else begin
            r_rdata_q <= w_rdata_d;
        end
    end

    assign o_rdata = r_rdata_q;

endmodule

`default_nettype wire

// File: rtl/hs_fifo_stage.sv
`default_nettype none
// ============================================================================
// Module      : hs_fifo_stage
// Description : Elastic req/ack buffer. Upstream it acts as a consumer
//               (req_l out, ack_l+din in); downstream it acts as a producer
//               (req_r in, ack_r+dout out). Strict FIFO order, DEPTH entries.
//               Define HS_FIFO_STATS_EN to add hwm/stall statistics ports.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef HS_PTR_W
`define HS_PTR_W(d) ($clog2(d))
`endif

module hs_fifo_stage
    import hs_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       req_l,
    input  logic                       ack_l,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       req_r,
    output logic                       ack_r,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [`HS_PTR_W(DEPTH):0]  level
`ifdef HS_FIFO_STATS_EN
    ,
    output logic [`HS_PTR_W(DEPTH):0]  hwm,
    output logic [31:0]                stall
`endif
);

    localparam int              c_aw   = `HS_PTR_W(DEPTH);
    localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

    logic [c_aw-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_aw-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_aw:0]   r_level_q,  w_level_d;
    logic            r_req_st_q, w_req_st_d;
    logic            r_ack_r_q,  w_ack_r_d;
    logic            w_push;
    logic            w_pop;

    // Next-state for pointers, occupancy and both handshake flags.
    always_comb begin
        // An ack at full has nowhere to go; it is dropped without a write.
        w_push     = ack_l && (r_level_q != c_full);
        // Freshly written data needs a cycle in storage, so level>0 gates the pop.
        w_pop      = req_r && !r_ack_r_q && (r_level_q != '0);

        w_level_d  = r_level_q;
        if (w_push && !w_pop) begin
            w_level_d = r_level_q + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_d = r_level_q - 1'b1;
        end

        w_wr_ptr_d = w_push ? (r_wr_ptr_q + 1'b1) : r_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? (r_rd_ptr_q + 1'b1) : r_rd_ptr_q;
        w_ack_r_d  = w_pop;

        // Request follows post-edge occupancy so a pop at full re-arms req_l at once.
        w_req_st_d = r_req_st_q;
        if (ack_l) begin
            w_req_st_d = (w_level_d != c_full) ? c_ST_WAIT_ACK : c_ST_IDLE;
        end else if ((r_req_st_q == c_ST_IDLE) && (w_level_d != c_full)) begin
            w_req_st_d = c_ST_WAIT_ACK;
        end
    end

    // Core state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
            r_req_st_q <= c_ST_IDLE;
            r_ack_r_q  <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
            r_req_st_q <= w_req_st_d;
            r_ack_r_q  <= w_ack_r_d;
        end
    end

    hs_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (c_aw)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr_q),
        .i_wdata (din),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr_q),
        .o_rdata (dout)
    );

    assign req_l = (r_req_st_q == c_ST_WAIT_ACK);
    assign ack_r = r_ack_r_q;
    assign level = r_level_q;

    // Upstream must never ack while every slot is occupied.
    a_no_ack_when_full : assert property (@(posedge clk) disable iff (rst)
        !(ack_l && (r_level_q == c_full)));

`ifdef HS_FIFO_STATS_EN
    logic [c_aw:0] r_hwm_q,   w_hwm_d;
    logic [31:0]   r_stall_q, w_stall_d;

    // High-water mark of occupancy and saturating count of starved consumer cycles.
    always_comb begin
        w_hwm_d   = (w_level_d > r_hwm_q) ? w_level_d : r_hwm_q;
        w_stall_d = r_stall_q;
        if (req_r && (r_level_q == '0) && !r_ack_r_q && (r_stall_q != 32'hFFFF_FFFF)) begin
            w_stall_d = r_stall_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hwm_q   <= '0;
            r_stall_q <= '0;
        end else begin
            r_hwm_q   <= w_hwm_d;
            r_stall_q <= w_stall_d;
        end
    end

    assign hwm   = r_hwm_q;
    assign stall = r_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hs_fifo_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_fifo_stage
// Description : Self-checking bench for hs_fifo_stage: directed vector table,
//               continuous-flow, mid-stream reset and randomized traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_fifo_stage;

    localparam int c_dw    = 32;
    localparam int c_depth = 4;
    localparam int c_aw    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_l;
    logic            ack_l;
    logic [c_dw-1:0] din;
    logic            req_r;
    logic            ack_r;
    logic [c_dw-1:0] dout;
    logic [c_aw:0]   level;
`ifdef HS_FIFO_STATS_EN
    logic [c_aw:0]   hwm;
    logic [31:0]     stall;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of stored items plus the three visible flags.
    logic [31:0] m_q[$];
    logic        m_req_l;
    logic        m_ack_r;
    logic [31:0] m_dout;

    // Producer state: next value to send, and whether it acked last cycle.
    logic [31:0] next_val;
    logic        prod_last;

    always #5 clk = ~clk;

    hs_fifo_stage #(
        .DATA_WIDTH (c_dw),
        .DEPTH      (c_depth)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req_l (req_l),
        .ack_l (ack_l),
        .din   (din),
        .req_r (req_r),
        .ack_r (ack_r),
        .dout  (dout),
        .level (level)
`ifdef HS_FIFO_STATS_EN
        ,
        .hwm   (hwm),
        .stall (stall)
`endif
    );

    typedef struct packed {
        logic        ack;
        logic [31:0] d;
        logic        rr;
        logic        e_req;
        logic        e_ackr;
        logic [2:0]  e_lvl;
        logic [31:0] e_dout;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic e_req, input logic e_ackr, input int e_lvl,
                                input int e_dout, input logic ack, input int d, input logic rr);
        vec_t v;
        v.e_req  = e_req;
        v.e_ackr = e_ackr;
        v.e_lvl  = 3'(e_lvl);
        v.e_dout = 32'(e_dout);
        v.ack    = ack;
        v.d      = 32'(d);
        v.rr     = rr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model, written from the handshake rules.
    task automatic model_edge(input logic a, input logic [31:0] d, input logic rr);
        bit pop;
        bit push;
        pop  = rr && !m_ack_r && (m_q.size() > 0);
        push = a && (m_q.size() < c_depth);
        m_ack_r = 1'b0;
        if (pop) begin
            m_dout  = m_q.pop_front();
            m_ack_r = 1'b1;
        end
        if (push) m_q.push_back(d);
        if (a) m_req_l = (m_q.size() < c_depth);
        else if (!m_req_l && (m_q.size() < c_depth)) m_req_l = 1'b1;
    endtask

    // Called at a negedge: drive inputs, take one posedge, return at next negedge.
    task automatic cycle(input logic a, input logic [31:0] d, input logic rr);
        ack_l = a;
        din   = d;
        req_r = rr;
        @(posedge clk);
        model_edge(a, d, rr);
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_req_l"}, 32'(req_l), 32'(m_req_l));
        check({tag, "_ack_r"}, 32'(ack_r), 32'(m_ack_r));
        check({tag, "_level"}, 32'(level), 32'(m_q.size()));
        check({tag, "_dout"},  dout,       m_dout);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_req_l   = 1'b0;
        m_ack_r   = 1'b0;
        m_dout    = '0;
        prod_last = 1'b0;
    endtask

    // Reset producer, consumer and DUT together; returns at a negedge.
    task automatic reset_all();
        rst   = 1'b1;
        ack_l = 1'b0;
        din   = '0;
        req_r = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Producer decision: ack only while requested, never two cycles running.
    task automatic produce(input bit allow, output logic a, output logic [31:0] d);
        a = m_req_l && !prod_last && allow;
        d = a ? next_val : 32'h0;
        if (a) next_val = next_val + 1;
        prod_last = a;
    endtask

    initial begin
        logic        a;
        logic [31:0] d;
        int          popped;
        int          cyc;
        int          duty;
        logic [31:0] exp_out;
        logic [31:0] exp_first;
        bit          seen;

        // ---------------- directed vector table ----------------
        //              e_req e_ackr lvl dout | ack din rr
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(1, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 1, 0, 1, 1, 0);
        vecs[4]  = mk(1, 0, 2, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 2, 0, 1, 2, 0);
        vecs[6]  = mk(1, 0, 3, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 3, 0, 1, 3, 0);
        vecs[8]  = mk(0, 0, 4, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 4, 0, 0, 0, 1);
        vecs[10] = mk(1, 1, 3, 0, 1, 4, 1);
        vecs[11] = mk(0, 0, 4, 0, 0, 0, 1);
        vecs[12] = mk(1, 1, 3, 1, 0, 0, 1);
        vecs[13] = mk(1, 0, 3, 1, 0, 0, 1);
        vecs[14] = mk(1, 1, 2, 2, 0, 0, 1);
        vecs[15] = mk(1, 0, 2, 2, 0, 0, 1);
        vecs[16] = mk(1, 1, 1, 3, 0, 0, 1);
        vecs[17] = mk(1, 0, 1, 3, 0, 0, 1);
        vecs[18] = mk(1, 1, 0, 4, 0, 0, 1);
        vecs[19] = mk(1, 0, 0, 4, 0, 0, 1);
        vecs[20] = mk(1, 0, 0, 4, 0, 0, 0);

        next_val = 32'd0;
        reset_all();
        for (int i = 0; i < 21; i++) begin
            check($sformatf("vec%0d_req_l", i), 32'(req_l), 32'(vecs[i].e_req));
            check($sformatf("vec%0d_ack_r", i), 32'(ack_r), 32'(vecs[i].e_ackr));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
            check($sformatf("vec%0d_dout", i),  dout,       vecs[i].e_dout);
            cycle(vecs[i].ack, vecs[i].d, vecs[i].rr);
        end
`ifdef HS_FIFO_STATS_EN
        check("hwm_after_drain", 32'(hwm), 32'd4);
        reset_all();
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);
        check("stall_count", stall, 32'd10);
`endif

        // ---------------- continuous flow, 5000 items ----------------
        reset_all();
        next_val = 32'd100;
        exp_out  = next_val;
        popped   = 0;
        cyc      = 0;
        duty     = 0;
        while (popped < 5000 && cyc < 12000) begin
            produce(1'b1, a, d);
            cycle(a, d, 1'b1);
            compare_model("flow");
            if (ack_r === 1'b1) begin
                if (dout !== exp_out) check("flow_order", dout, exp_out);
                exp_out = exp_out + 1;
                popped++;
                if (cyc >= 100 && cyc < 1100) duty++;
            end
            cyc++;
        end
        check("flow_count", 32'(popped), 32'd5000);
        check("flow_duty", 32'(duty), 32'd500);

        // ---------------- reset mid-stream at level 2 ----------------
        reset_all();
        for (int i = 0; i < 20; i++) begin
            produce(1'b1, a, d);
            cycle(a, d, 1'b1);
            compare_model("pre_rst");
        end
        cyc = 0;
        while (m_q.size() != 2 && cyc < 20) begin
            produce(1'b1, a, d);
            cycle(a, d, 1'b0);
            compare_model("fill2");
            cyc++;
        end
        check("fill2_level", 32'(level), 32'd2);
        #2;
        rst   = 1'b1;
        ack_l = 1'b0;
        req_r = 1'b0;
        #1;
        check("async_rst_req_l", 32'(req_l), 32'd0);
        check("async_rst_ack_r", 32'(ack_r), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_dout",  dout,       32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_first = next_val;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            produce(1'b1, a, d);
            cycle(a, d, 1'b1);
            compare_model("post_rst");
            if (ack_r === 1'b1) begin
                check("post_rst_first_dout", dout, exp_first);
                seen = 1'b1;
            end
            cyc++;
        end
        if (!seen) check("post_rst_timeout", 32'(seen), 32'd1);

        // ---------------- randomized traffic ----------------
        reset_all();
        for (int i = 0; i < 3000; i++) begin
            produce($urandom_range(0, 3) != 0, a, d);
            cycle(a, d, 1'(($urandom_range(0, 2) != 0)));
            compare_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
